vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Generates VGA raster timing: hsync/vsync, active-video flag and the current
//   pixel coordinate (draw_xpos_o/draw_ypos_o). Feeds the colour-mapping stage
//   directly and drives the DAC/HDMI sync pins. Also emits per-frame strobes
//   (frame start, vblank start) and a frame counter for game/animation logic.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   hsync pulse width (pixels)
//   H_BP      48   horizontal back porch (pixels)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vsync pulse width (lines)
//   V_BP      33   vertical back porch (lines)
//   CLK_DIV   2    system clocks per pixel (>=1); 50 MHz / 2 = 25 MHz pixel rate
//   SYNC_POL  0    asserted level of hsync_o/vsync_o (0 = active-low)
// PORTS
//   clk_i           in   1   system clock
//   rst_ni          in   1   asynchronous active-low reset
//   pixel_ce_o      out  1   1-clk pixel enable, high once every CLK_DIV clocks
//   draw_xpos_o     out  10  current column, 0..H_TOTAL-1
//   draw_ypos_o     out  10  current line, 0..V_TOTAL-1
//   display_o       out  1   1 when (x,y) in active area
//   hsync_o         out  1   horizontal sync, level per SYNC_POL
//   vsync_o         out  1   vertical sync, level per SYNC_POL
//   frame_start_o   out  1   1-clk pulse when position becomes (0,0)
//   vblank_start_o  out  1   1-clk pulse when position becomes (0,V_ACTIVE)
//   frame_count_o   out  16  frames started since reset, wraps at 2^16
// BEHAVIOUR
//   - One clock, one async active-low reset; all state flops reset on rst_ni=0.
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525);
//     both must be <=1024 (10-bit counters); elaboration error otherwise.
//   - Divider: counter 0..CLK_DIV-1, reset 0; pixel_ce_o=1 when it equals
//     CLK_DIV-1, then wraps to 0. CLK_DIV=1 -> pixel_ce_o constantly 1 after reset.
//   - Position advances only on clocks with pixel_ce_o=1: x+1; at x=H_TOTAL-1
//     x->0 and y+1; at (H_TOTAL-1,V_TOTAL-1) both -> 0.
//   - Reset: x=H_TOTAL-1, y=V_TOTAL-1 (last pixel of frame) so the first pixel_ce
//     lands on (0,0). Reset outputs: display_o=0, hsync_o=vsync_o=~SYNC_POL,
//     pixel_ce_o=0, frame_start_o=0, vblank_start_o=0, frame_count_o=0.
//   - All decoded outputs are registered and updated on the same edge as the
//     position; they always describe the position currently on draw_x/ypos_o
//     (zero relative latency, no glitches):
//       display_o = (x<H_ACTIVE) && (y<V_ACTIVE)
//       hsync_o   = SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
//       vsync_o   = SYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC
//   - frame_start_o/vblank_start_o: high exactly one clk (not one pixel) on the
//     edge where the position changes to the stated value; low otherwise.
//   - frame_count_o increments on the same edge frame_start_o rises; the first
//     pixel_ce after reset gives frame_count_o=1. 0xFFFF wraps to 0x0000.
//   - Reset mid-frame: immediate return to reset values; no partial sync pulse
//     is held beyond reset assertion.
//   - Position holds between pixel enables (stable for CLK_DIV clocks).
// TESTING
//   1 Reset, CLK_DIV=2: outputs = (799,524), display 0, syncs 1, count 0; 2nd clk
//     after release -> pixel_ce=1, pos (0,0), display 1, frame_start 1, count 1.
//   2 Line scan: hsync_o low for exactly x=656..751 (96 px = 192 clks); display
//     falls at x=640; line period 1600 clks.
//   3 Frame scan: vsync_o low for lines 490..491 only; vblank_start pulse at
//     (0,480); display high for 307200 pixel_ce per frame; frame period 840000 clks.
//   4 Assert rst_ni at (300,200) for 3 clks -> all outputs return to reset values
//     asynchronously; restart identical to scenario 1.
//   5 CLK_DIV=1, SYNC_POL=1: pixel_ce constantly 1, hsync_o high x=656..751,
//     frame period 420000 clks.
//   6 Force frame_count to 0xFFFF (run 65536 frames or preload in sim) -> next
//     frame_start gives frame_count_o=0x0000.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, position counters, registered
// sync/active decode and per-frame strobes with a 16-bit frame counter.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        pixel_ce_o,
    output logic [9:0]  draw_xpos_o,
    output logic [9:0]  draw_ypos_o,
    output logic        display_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_start_o,
    output logic        vblank_start_o,
    output logic [15:0] frame_count_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST_C   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST_C   = 10'(V_TOTAL - 1);
    // 11-bit bounds so an end-of-range equal to 1024 still compares correctly
    localparam logic [10:0]      H_ACT_C    = 11'(H_ACTIVE);
    localparam logic [10:0]      V_ACT_C    = 11'(V_ACTIVE);
    localparam logic [10:0]      HS_BEG_C   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      HS_END_C   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]      VS_BEG_C   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]      VS_END_C   = 11'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_err
            $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       xpos_q, xpos_d;
    logic [9:0]       ypos_q, ypos_d;
    logic             pixel_ce_q, pixel_ce_d;
    logic             display_q, display_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;
    logic             vblank_start_q, vblank_start_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             tick_s;
    logic [10:0]      x_ext_s, y_ext_s;

    // Next-state: divider, position advance and decode of the new position
    always_comb begin
        tick_s = (div_q == DIV_LAST_C);
        div_d  = tick_s ? {DIV_W{1'b0}} : (div_q + DIV_W'(1));
        xpos_d = xpos_q;
        ypos_d = ypos_q;
        if (tick_s) begin
            if (xpos_q == H_LAST_C) begin
                xpos_d = 10'd0;
                if (ypos_q == V_LAST_C) begin
                    ypos_d = 10'd0;
                end else begin
                    ypos_d = ypos_q + 10'd1;
                end
            end else begin
                xpos_d = xpos_q + 10'd1;
            end
        end else begin
            xpos_d = xpos_q;
        end

        // Decode the position being loaded so outputs line up with it
        x_ext_s        = {1'b0, xpos_d};
        y_ext_s        = {1'b0, ypos_d};
        pixel_ce_d     = tick_s;
        display_d      = (x_ext_s < H_ACT_C) && (y_ext_s < V_ACT_C);
        hsync_d        = ((x_ext_s >= HS_BEG_C) && (x_ext_s < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
        vsync_d        = ((y_ext_s >= VS_BEG_C) && (y_ext_s < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
        frame_start_d  = tick_s && (xpos_d == 10'd0) && (ypos_d == 10'd0);
        vblank_start_d = tick_s && (xpos_d == 10'd0) && (y_ext_s == V_ACT_C);
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // State registers; reset parks on the last pixel so the first tick lands on (0,0)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q          <= {DIV_W{1'b0}};
            xpos_q         <= H_LAST_C;
            ypos_q         <= V_LAST_C;
            pixel_ce_q     <= 1'b0;
            display_q      <= 1'b0;
            hsync_q        <= ~SYNC_POL;
            vsync_q        <= ~SYNC_POL;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 16'd0;
        end else begin
            div_q          <= div_d;
            xpos_q         <= xpos_d;
            ypos_q         <= ypos_d;
            pixel_ce_q     <= pixel_ce_d;
            display_q      <= display_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign pixel_ce_o     = pixel_ce_q;
    assign draw_xpos_o    = xpos_q;
    assign draw_ypos_o    = ypos_q;
    assign display_o      = display_q;
    assign hsync_o        = hsync_q;
    assign vsync_o        = vsync_q;
    assign frame_start_o  = frame_start_q;
    assign vblank_start_o = vblank_start_q;
    assign frame_count_o  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two instances on a reduced raster
// (CLK_DIV=2 active-low sync, CLK_DIV=1 active-high sync) checked every clock.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic        ce;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        disp;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        vb;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        pce_a, disp_a, hs_a, vs_a, fs_a, vb_a;
    logic [9:0]  x_a, y_a;
    logic [15:0] fc_a;
    logic        pce_b, disp_b, hs_b, vs_b, fs_b, vb_b;
    logic [9:0]  x_b, y_b;
    logic [15:0] fc_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .pixel_ce_o(pce_a),
        .draw_xpos_o(x_a), .draw_ypos_o(y_a), .display_o(disp_a),
        .hsync_o(hs_a), .vsync_o(vs_a), .frame_start_o(fs_a),
        .vblank_start_o(vb_a), .frame_count_o(fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .pixel_ce_o(pce_b),
        .draw_xpos_o(x_b), .draw_ypos_o(y_b), .display_o(disp_b),
        .hsync_o(hs_b), .vsync_o(vs_b), .frame_start_o(fs_b),
        .vblank_start_o(vb_b), .frame_count_o(fc_b)
    );

    obs_t qa[$];
    obs_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;
    int   fc_off_a = 0;

    // Reference raster: k = clocks since reset release, ticks every div clocks
    function automatic obs_t model(int kk, int div, logic pol, int off);
        obs_t e;
        int   tot, n, p, x, y;
        logic tick;
        tot    = HT * VT;
        n      = kk / div;
        tick   = (kk > 0) && ((kk % div) == 0);
        p      = (n + tot - 1) % tot;
        x      = p % HT;
        y      = p / HT;
        e.ce   = tick;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.disp = (x < HA) && (y < VA);
        e.hs   = ((x >= HA + HF) && (x < HA + HF + HS)) ? pol : ~pol;
        e.vs   = ((y >= VA + VF) && (y < VA + VF + VS)) ? pol : ~pol;
        e.fs   = tick && (p == 0);
        e.vb   = tick && (p == VA * HT);
        e.fc   = 16'(((n + tot - 1) / tot) + off);
        return e;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o.ce = pce_a; o.x = x_a; o.y = y_a; o.disp = disp_a; o.hs = hs_a;
        o.vs = vs_a; o.fs = fs_a; o.vb = vb_a; o.fc = fc_a;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.ce = pce_b; o.x = x_b; o.y = y_b; o.disp = disp_b; o.hs = hs_b;
        o.vs = vs_b; o.fs = fs_b; o.vb = vb_b; o.fc = fc_b;
        return o;
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_obs(string nm, obs_t got, obs_t e);
        string t;
        t = $sformatf("%s@k%0d", nm, k);
        check_eq({t, ".ce"},   32'(got.ce),   32'(e.ce));
        check_eq({t, ".x"},    32'(got.x),    32'(e.x));
        check_eq({t, ".y"},    32'(got.y),    32'(e.y));
        check_eq({t, ".disp"}, 32'(got.disp), 32'(e.disp));
        check_eq({t, ".hs"},   32'(got.hs),   32'(e.hs));
        check_eq({t, ".vs"},   32'(got.vs),   32'(e.vs));
        check_eq({t, ".fs"},   32'(got.fs),   32'(e.fs));
        check_eq({t, ".vb"},   32'(got.vb),   32'(e.vb));
        check_eq({t, ".fc"},   32'(got.fc),   32'(e.fc));
    endtask

    // One clock: push expectations at the edge, pop and compare at the negedge
    task automatic step();
        obs_t ea, eb;
        @(posedge clk);
        k++;
        qa.push_back(model(k, 2, 1'b0, fc_off_a));
        qb.push_back(model(k, 1, 1'b1, 0));
        @(negedge clk);
        ea = qa.pop_front();
        eb = qb.pop_front();
        check_obs("A", obs_a(), ea);
        check_obs("B", obs_b(), eb);
    endtask

    initial begin
        int disp_cnt_a, hs_clk_a, hs_clk_b, vb_cnt_a, fs_cnt_a;
        disp_cnt_a = 0; hs_clk_a = 0; hs_clk_b = 0; vb_cnt_a = 0; fs_cnt_a = 0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_obs("A_rst", obs_a(), model(0, 2, 1'b0, 0));
        check_obs("B_rst", obs_b(), model(0, 1, 1'b1, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            step();
            if (k >= 2 && k <= 301) begin
                disp_cnt_a += int'(pce_a && disp_a);
                vb_cnt_a   += int'(vb_a);
                fs_cnt_a   += int'(fs_a);
            end
            if (k >= 2 && k <= 31) hs_clk_a += int'(!hs_a);
            if (k >= 1 && k <= 15) hs_clk_b += int'(hs_b);
        end
        check_eq("disp_ticks_per_frame_A", 32'(disp_cnt_a), 32'(HA * VA));
        check_eq("hsync_clks_per_line_A",  32'(hs_clk_a),   32'(HS * 2));
        check_eq("hsync_clks_per_line_B",  32'(hs_clk_b),   32'(HS));
        check_eq("vblank_pulses_A",        32'(vb_cnt_a),   32'd1);
        check_eq("frame_pulses_A",         32'(fs_cnt_a),   32'd1);

        // Asynchronous reset mid-frame, away from any clock edge
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        k = 0;
        check_obs("A_async_rst", obs_a(), model(0, 2, 1'b0, 0));
        check_obs("B_async_rst", obs_b(), model(0, 1, 1'b1, 0));
        repeat (3) @(posedge clk);
        #1;
        check_obs("A_rst_hold", obs_a(), model(0, 2, 1'b0, 0));
        check_obs("B_rst_hold", obs_b(), model(0, 1, 1'b1, 0));
        @(negedge clk);
        rst_n = 1'b1;

        repeat (100) step();
        // Preload the frame counter to its wrap boundary, mid-frame
        force dut_a.frame_count_q = 16'hFFFF;
        fc_off_a = 16'hFFFF - int'(model(k, 2, 1'b0, 0).fc);
        step();
        release dut_a.frame_count_q;
        for (int i = 0; i < 400; i++) begin
            step();
            if (k == 302) begin
                check_eq("wrap_fs_A", 32'(fs_a), 32'd1);
                check_eq("wrap_fc_A", 32'(fc_a), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
